// File: rtl/dft_stream_buffer_if.sv
// Bundles the software-side X/Y buffer signals, the start/status lines and
// the streaming DFT core handshake between the stream buffer and its peers.
// Ports: x_wr_* / y_rd_* buffer access, start_i, busy_o, done_o,
//        core_next_o, core_x_o, core_next_out_i, core_y_i,
//        timeout_o when DFT_STREAM_BUFFER_TIMEOUT_EN is defined.
// slave = the stream buffer itself; master = the driving side.
interface dft_stream_buffer_if #(
   parameter int SW    = 16,
   parameter int DEPTH = 32
);
   localparam int IW = $clog2(DEPTH);
   localparam int WW = 4 * SW;

   logic          x_wr_en_i;
   logic [IW-1:0] x_wr_idx_i;
   logic [WW-1:0] x_wr_data_i;
   logic [IW-1:0] y_rd_idx_i;
   logic [WW-1:0] y_rd_data_o;
   logic          start_i;
   logic          busy_o;
   logic          done_o;
   logic          core_next_o;
   logic [WW-1:0] core_x_o;
   logic          core_next_out_i;
   logic [WW-1:0] core_y_i;
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
   logic          timeout_o;
`endif

   modport slave (
      input  x_wr_en_i, x_wr_idx_i, x_wr_data_i,
      input  y_rd_idx_i,
      output y_rd_data_o,
      input  start_i,
      output busy_o, done_o,
      output core_next_o, core_x_o,
      input  core_next_out_i, core_y_i
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
      , output timeout_o
`endif
   );

   modport master (
      output x_wr_en_i, x_wr_idx_i, x_wr_data_i,
      output y_rd_idx_i,
      input  y_rd_data_o,
      output start_i,
      input  busy_o, done_o,
      input  core_next_o, core_x_o,
      output core_next_out_i, core_y_i
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
      , input timeout_o
`endif
   );
endinterface

// File: rtl/dft_stream_buffer.sv
// Buffers 32 software-written X words, streams them into the DFT core after
// a start edge and captures the core's 32-word output burst into Y storage.
// Ports: clk_i, rst_ni (async, active-low), bus (dft_stream_buffer_if.slave).
// Optional WAIT watchdog: define DFT_STREAM_BUFFER_TIMEOUT_EN.
module dft_stream_buffer #(
   parameter int SW    = 16,
   parameter int DEPTH = 32
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input logic                clk_i,
   input logic                rst_ni,
   dft_stream_buffer_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int WW = 4 * SW;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   typedef logic [WW-1:0] word_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEXT,
      S_STREAM,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [IW-1:0] cnt, cnt_n;
   logic          start_q;
   logic          start_req;
   logic          busy;
   word_t         y_rd_q;

   word_t x_mem [DEPTH];
   word_t y_mem [DEPTH];

`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tcnt, tcnt_n;
   logic          timeout, timeout_n;
`endif

   // Only a 0->1 transition of the start level launches a run.
   assign start_req = bus.start_i & ~start_q;

   assign busy = state inside {S_NEXT, S_STREAM, S_WAIT, S_CAPTURE};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= S_IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
         y_rd_q  <= '0;
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
         tcnt    <= '0;
         timeout <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         start_q <= bus.start_i;
         y_rd_q  <= y_mem[bus.y_rd_idx_i];
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
         tcnt    <= tcnt_n;
         timeout <= timeout_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
      tcnt_n    = tcnt;
      timeout_n = timeout;
`endif
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start_req) begin
               state_n = S_NEXT;
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
               timeout_n = 1'b0;
`endif
            end
         end
         S_NEXT: begin
            state_n = S_STREAM;
            cnt_n   = '0;
         end
         S_STREAM: begin
            if (cnt == LAST) begin
               state_n = S_WAIT;
               cnt_n   = '0;
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
               tcnt_n  = '0;
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.core_next_out_i) begin
               state_n = S_CAPTURE;
               cnt_n   = '0;
            end
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
            else if (tcnt == TLAST) begin
               state_n   = S_IDLE;
               timeout_n = 1'b1;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
`endif
         end
         S_CAPTURE: begin
            if (cnt == LAST) begin
               state_n = S_DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Storage arrays carry no reset so their contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (bus.x_wr_en_i && !busy)
         x_mem[bus.x_wr_idx_i] <= bus.x_wr_data_i;
      if (state == S_CAPTURE)
         y_mem[cnt] <= bus.core_y_i;
   end

   // Status decoded from state so reset drops them asynchronously.
   assign bus.busy_o      = busy;
   assign bus.done_o      = (state == S_DONE);
   assign bus.core_next_o = (state == S_NEXT);
   assign bus.core_x_o    = (state == S_STREAM) ? x_mem[cnt] : '0;
   assign bus.y_rd_data_o = y_rd_q;
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
   assign bus.timeout_o   = timeout;
`endif

endmodule

// File: tb/tb_dft_stream_buffer.sv
// Directed bench for dft_stream_buffer with X/Y scoreboards.
// Ports: none; drives the design through dft_stream_buffer_if.
module tb_dft_stream_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
   dft_stream_buffer_if bus ();
   dft_stream_buffer #(.TIMEOUT_CYCLES(64)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );
`else
   dft_stream_buffer_if bus ();
   dft_stream_buffer dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] xmodel [32];
   logic [63:0] ymodel [32];
   logic [63:0] xq [$];
   logic [63:0] yq [$];

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_stream();
      for (int j = 0; j < 32; j++) xq.push_back(xmodel[j]);
   endtask

   // Caller has just driven start_i=1 at a negedge.
   task automatic stream_check(input int abort_at, input bit disturb,
                               input bit hold_start);
      int waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (bus.core_next_o !== 1'b1 && waited < 8);
      bus.x_wr_en_i = 1'b0;
      if (!hold_start) bus.start_i = 1'b0;
      check("next_latency", 64'(waited), 64'd1);
      check("next_done_clr", {63'd0, bus.done_o}, 64'd0);
      check("next_busy", {63'd0, bus.busy_o}, 64'd1);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         check("stream_x", bus.core_x_o, xq.pop_front());
         check("no_next", {63'd0, bus.core_next_o}, 64'd0);
         if (disturb) begin
            case (k)
               5: begin
                  bus.x_wr_en_i   = 1'b1;
                  bus.x_wr_idx_i  = 5'd0;
                  bus.x_wr_data_i = '1;
                  bus.start_i     = 1'b1;
               end
               6: begin
                  bus.x_wr_en_i = 1'b0;
                  bus.start_i   = 1'b0;
               end
               8: bus.core_next_out_i = 1'b1;
               9: bus.core_next_out_i = 1'b0;
               default: ;
            endcase
         end
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
            check("rst_next", {63'd0, bus.core_next_o}, 64'd0);
            check("rst_done", {63'd0, bus.done_o}, 64'd0);
            check("rst_x", bus.core_x_o, 64'd0);
            xq.delete();
            return;
         end
      end
      @(negedge clk);
      check("x_after", bus.core_x_o, 64'd0);
      check("wait_busy", {63'd0, bus.busy_o}, 64'd1);
   endtask

   // Called at the negedge of the first WAIT cycle.
   task automatic core_respond(input logic [63:0] base, input int delay);
      repeat (delay - 1) @(negedge clk);
      check("wait_hold", {62'd0, bus.busy_o, bus.done_o}, 64'd2);
      bus.core_next_out_i = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         bus.core_next_out_i = 1'b0;
         bus.core_y_i = base + 64'(k);
         ymodel[k] = base + 64'(k);
      end
      check("done_pre", {63'd0, bus.done_o}, 64'd0);
      @(negedge clk);
      bus.core_y_i = '0;
      check("done_rise", {63'd0, bus.done_o}, 64'd1);
      check("done_busy", {63'd0, bus.busy_o}, 64'd0);
   endtask

   task automatic read_check(input int idx);
      bus.y_rd_idx_i = 5'(idx);
      yq.push_back(ymodel[idx]);
      @(negedge clk);
      check("y_rd", bus.y_rd_data_o, yq.pop_front());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      bus.x_wr_en_i       = 1'b0;
      bus.x_wr_idx_i      = '0;
      bus.x_wr_data_i     = '0;
      bus.y_rd_idx_i      = '0;
      bus.start_i         = 1'b0;
      bus.core_next_out_i = 1'b0;
      bus.core_y_i        = '0;

      repeat (3) @(negedge clk);
      check("rst_busy0", {63'd0, bus.busy_o}, 64'd0);
      check("rst_done0", {63'd0, bus.done_o}, 64'd0);
      check("rst_next0", {63'd0, bus.core_next_o}, 64'd0);
      check("rst_x0", bus.core_x_o, 64'd0);
      check("rst_yrd0", bus.y_rd_data_o, 64'd0);
`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
      check("rst_to0", {63'd0, bus.timeout_o}, 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Load X buffer
      for (int j = 0; j < 32; j++) begin
         xmodel[j] = {16'(4*j+3), 16'(4*j+2), 16'(4*j+1), 16'(4*j)};
         bus.x_wr_en_i   = 1'b1;
         bus.x_wr_idx_i  = 5'(j);
         bus.x_wr_data_i = xmodel[j];
         @(negedge clk);
      end
      bus.x_wr_en_i = 1'b0;

      // Run A: basic stream and capture
      bus.start_i = 1'b1;
      push_stream();
      stream_check(-1, 1'b0, 1'b0);
      core_respond(64'h1000_0000_0000_0000, 10);
      read_check(5);
      read_check(0);
      read_check(31);

      // Run B: writes, start and core pulse during STREAM are ignored
      bus.start_i = 1'b1;
      push_stream();
      stream_check(-1, 1'b1, 1'b0);
      core_respond(64'h2000_0000_0000_0000, 10);
      read_check(5);

      // Run C: original word 0 streams, then reset at cnt 12
      check("x0_model", xmodel[0], 64'h0003_0002_0001_0000);
      bus.start_i = 1'b1;
      push_stream();
      stream_check(12, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      read_check(5);

      // Run D: full stream after reset, start held high throughout
      bus.start_i = 1'b1;
      push_stream();
      stream_check(-1, 1'b0, 1'b1);
      core_respond(64'h3000_0000_0000_0000, 4);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.core_next_o !== 1'b0 || bus.done_o !== 1'b1) bad++;
      end
      check("hold_no_retrig", 64'(bad), 64'd0);
      read_check(31);

      // Run E: new edge with a same-cycle X write
      bus.start_i = 1'b0;
      @(negedge clk);
      bus.start_i     = 1'b1;
      bus.x_wr_en_i   = 1'b1;
      bus.x_wr_idx_i  = 5'd3;
      bus.x_wr_data_i = 64'hABCD_1234_5678_9ABC;
      xmodel[3]       = 64'hABCD_1234_5678_9ABC;
      push_stream();
      stream_check(-1, 1'b0, 1'b0);
      core_respond(64'h4000_0000_0000_0000, 2);
      read_check(17);

`ifdef DFT_STREAM_BUFFER_TIMEOUT_EN
      // Run F: core never answers
      bus.start_i = 1'b1;
      push_stream();
      stream_check(-1, 1'b0, 1'b0);
      repeat (63) @(negedge clk);
      check("to_pre", {62'd0, bus.timeout_o, bus.busy_o}, 64'd1);
      @(negedge clk);
      check("to_set", {63'd0, bus.timeout_o}, 64'd1);
      check("to_busy", {63'd0, bus.busy_o}, 64'd0);
      check("to_done", {63'd0, bus.done_o}, 64'd0);
      bus.start_i = 1'b1;
      push_stream();
      stream_check(-1, 1'b0, 1'b0);
      check("to_clr", {63'd0, bus.timeout_o}, 64'd0);
      core_respond(64'h5000_0000_0000_0000, 3);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
